snake_renderer: RTL
===================

# snake_renderer

Parametrised snake-game core combining body tracking with pixel rendering. Holds up to MAX_LEN body segments in a shift register, advances the snake on move requests during vertical blank, detects wall/obstacle/self collisions and food capture, and produces registered 1-bit RGB for the VGA output stage from the timing generator's pixel position.

## Interface
- GRID_W, 25: play-field width in cells
- GRID_H, 20: play-field height in cells
- CELL_PX, 20: cell edge in pixels
- FENCE_PX, 10: pixel offset of play field from top-left of screen
- MAX_LEN, 8: maximum snake length in segments (≥ INIT_LEN+1)
- INIT_LEN, 3: length after reset
- CW, 5: cell-coordinate width
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; leaves IDLE
- move  in  1  pulse; request one step
- dir  in  2  00 right, 01 down, 10 left, 11 up; sampled with move
- level  in  2  obstacle set, 0–3
- food_x, food_y  in  CW  food cell
- blank  in  1  blanking from timing generator
- pos_h, pos_v  in  10  screen pixel position (0,0 top-left)
- red, green, blue  out  1  pixel colour
- head_x, head_y  out  CW  current head cell
- length  out  clog2(MAX_LEN+1)  active segment count
- ate_food  out  1  one-cycle pulse on food capture
- hit_wall, hit_self  out  1  sticky collision flags
- state  out  2  00 IDLE, 01 RUN, 10 DEAD

## Operation
- Reset: head=(GRID_W/2, GRID_H/2), segments i=1..INIT_LEN-1 at (head_x−i, head_y); length=INIT_LEN; heading right; state IDLE; RGB, flags, ate_food, pending = 0.
- IDLE→RUN on start. move ignored in IDLE and DEAD. DEAD exits only via rst.
- move in RUN sets pending and latches dir; further moves while pending overwrite dir (merge to one step). dir opposite current heading is replaced by current heading.
- Step is applied on first cycle with pending=1 and pos_v ≥ 480; pending clears same cycle.
- Step: next = head ± 1 in heading axis. Order of checks: (1) next outside grid → hit_wall, DEAD; (2) next in active obstacle → hit_wall, DEAD; (3) next equals any active segment except the tail (tail included if food will be eaten) → hit_self, DEAD; (4) otherwise shift segments, head=next; if next==food: ate_food pulse, length+1 saturating at MAX_LEN (at MAX_LEN snake moves without growth, ate_food still pulses). On death, segments are not updated.
- Obstacles (cells, inclusive ranges), cumulative with level: L≥1 x1–4,y1–2; L≥2 x6–9,y4–5; L≥3 x11–14,y7–8.
- Rendering: cell (cx,cy) covers pixels x∈[FENCE_PX+cx·CELL_PX, +CELL_PX), y likewise; compare by multiplication of constants only, no division. Priority: blank → 000; outside play field → blue; head → green+blue; body → green (red+green in DEAD); food → red; obstacle → red+blue; else 000.

## Timing
- Render pipeline 2 cycles: stage 1 registers per-segment/food/obstacle/fence hit flags and blank; stage 2 registers priority-muxed RGB. RGB at cycle N+2 corresponds to pos at N.
- Step evaluated and committed in the single applying cycle; head_x/head_y/length/flags update at the following edge; ate_food high for exactly that one cycle.
- rst mid-frame or with pending set: all state returns to reset values next edge; pipeline outputs 000 for 2 cycles.
- move and step-apply in same cycle: the step uses previously latched dir; the new move re-arms pending for the next vertical blank.

## Configuration
- SNAKE_WRAP_EN defined: check (1) removed; next wraps modulo GRID_W/GRID_H (x=GRID_W−1 moving right → 0, y=0 moving up → GRID_H−1). Obstacle and self checks unchanged.
- Undefined: grid exit sets hit_wall, state DEAD.

## Test plan
- rst, start, move dir=00, pos_v sweeps to 480 → head (13,10), length 3, RGB at pixel (270,210) = green+blue two cycles after pos presented.
- Food at (13,10), move right from reset → ate_food one cycle, length 4; repeat to MAX_LEN then once more → length stays 8, ate_food pulses.
- Head (24,10) heading right, move → hit_wall=1, state DEAD, head unchanged; with SNAKE_WRAP_EN head=(0,10), state RUN.
- Length 5, moves down, left, up into body → hit_self=1, DEAD, body pixels red+green.
- level=1, steer into cell (4,2) → hit_wall; level=0 same path → no collision.
- Two moves before vertical blank (dir 01 then 10 while heading right) → exactly one step, heading left rejected, head moves right; rst asserted with pending → no step, reset values.

Source files
------------

// File: rtl/snake_renderer.sv
`default_nettype none
// ============================================================================
// snake_renderer - snake body tracking, step/collision logic and a 2-stage
// 1-bit RGB renderer. Define SNAKE_WRAP_EN to wrap at grid edges. Rev 1.0
// ============================================================================
module snake_renderer #(
  parameter int GRID_W   = 25,
  parameter int GRID_H   = 20,
  parameter int CELL_PX  = 20,
  parameter int FENCE_PX = 10,
  parameter int MAX_LEN  = 8,
  parameter int INIT_LEN = 3,
  parameter int CW       = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         move,
  input  logic [1:0]                   dir,
  input  logic [1:0]                   level,
  input  logic [CW-1:0]                food_x,
  input  logic [CW-1:0]                food_y,
  input  logic                         blank,
  input  logic [9:0]                   pos_h,
  input  logic [9:0]                   pos_v,
  output logic                         red,
  output logic                         green,
  output logic                         blue,
  output logic [CW-1:0]                head_x,
  output logic [CW-1:0]                head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         ate_food,
  output logic                         hit_wall,
  output logic                         hit_self,
  output logic [1:0]                   state
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam int PW = 12;
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } state_t;

  state_t        st;
  logic [CW-1:0] seg_x [MAX_LEN];
  logic [CW-1:0] seg_y [MAX_LEN];
  logic [LW-1:0] len;
  logic [1:0]    heading;
  logic [1:0]    pend_dir;
  logic          pending;

  function automatic logic cell_in(input logic [CW-1:0] c, input int lo, input int hi);
    cell_in = (c >= CW'(lo)) && (c <= CW'(hi));
  endfunction

  function automatic logic obs_cell(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                    input logic [1:0] lvl);
    obs_cell = (lvl >= 2'd1 && cell_in(x, 1, 4)   && cell_in(y, 1, 2)) ||
               (lvl >= 2'd2 && cell_in(x, 6, 9)   && cell_in(y, 4, 5)) ||
               (lvl == 2'd3 && cell_in(x, 11, 14) && cell_in(y, 7, 8));
  endfunction

  // Pixel p lies inside cells lo..hi of one axis.
  function automatic logic rng(input logic [9:0] p, input int lo, input int hi);
    rng = ({2'b00, p} >= PW'(FENCE_PX + lo * CELL_PX)) &&
          ({2'b00, p} <  PW'(FENCE_PX + (hi + 1) * CELL_PX));
  endfunction

  function automatic logic span(input logic [9:0] p, input logic [CW-1:0] c);
    logic [PW-1:0] lo;
    lo   = PW'(FENCE_PX) + PW'(c) * PW'(CELL_PX);
    span = ({2'b00, p} >= lo) && ({2'b00, p} < lo + PW'(CELL_PX));
  endfunction

  // ---------------- step evaluation ----------------
  logic          apply;
  logic [CW-1:0] nx, ny;
  logic          exit_grid, next_obs, next_self, next_food, wall_hit;
  logic [1:0]    eff_heading;

  assign apply       = (st == RUN) && pending && (pos_v >= 10'd480);
  assign eff_heading = apply ? pend_dir : heading;

  always_comb begin
    nx        = seg_x[0];
    ny        = seg_y[0];
    exit_grid = 1'b0;
    case (pend_dir)
      2'b00: if (seg_x[0] == CW'(GRID_W-1)) begin exit_grid = 1'b1; nx = '0; end
             else nx = seg_x[0] + CW'(1);
      2'b01: if (seg_y[0] == CW'(GRID_H-1)) begin exit_grid = 1'b1; ny = '0; end
             else ny = seg_y[0] + CW'(1);
      2'b10: if (seg_x[0] == '0) begin exit_grid = 1'b1; nx = CW'(GRID_W-1); end
             else nx = seg_x[0] - CW'(1);
      default: if (seg_y[0] == '0) begin exit_grid = 1'b1; ny = CW'(GRID_H-1); end
               else ny = seg_y[0] - CW'(1);
    endcase
  end

  always_comb begin
    next_obs  = obs_cell(nx, ny, level);
    wall_hit  = next_obs | (exit_grid & ~WRAP);
    next_food = (nx == food_x) && (ny == food_y);
    next_self = 1'b0;
    // The tail vacates its cell unless the snake grows on this step.
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < len) && ((LW'(i) != len - LW'(1)) || next_food) &&
          (seg_x[i] == nx) && (seg_y[i] == ny))
        next_self = 1'b1;
    end
  end

  // ---------------- game state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      len      <= LW'(INIT_LEN);
      heading  <= 2'b00;
      pend_dir <= 2'b00;
      pending  <= 1'b0;
      hit_wall <= 1'b0;
      hit_self <= 1'b0;
      ate_food <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= CW'(GRID_W/2 - i);
        seg_y[i] <= CW'(GRID_H/2);
      end
    end else begin
      ate_food <= 1'b0;
      case (st)
        IDLE: if (start) st <= RUN;
        RUN: begin
          if (apply) begin
            pending <= 1'b0;
            if (wall_hit) begin
              hit_wall <= 1'b1;
              st       <= DEAD;
            end else if (next_self) begin
              hit_self <= 1'b1;
              st       <= DEAD;
            end else begin
              heading  <= pend_dir;
              seg_x[0] <= nx;
              seg_y[0] <= ny;
              for (int i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
              end
              if (next_food) begin
                ate_food <= 1'b1;
                if (len != LW'(MAX_LEN)) len <= len + LW'(1);
              end
            end
          end
          if (move) begin
            pending  <= 1'b1;
            pend_dir <= ((dir ^ 2'b10) == eff_heading) ? eff_heading : dir;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign length = len;
  assign state  = st;

  // ---------------- render pipeline ----------------
  logic [MAX_LEN-1:0] s1_seg;
  logic               s1_food, s1_obs, s1_out, s1_blank, s1_dead;
  logic [2:0]         rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_seg   <= '0;
      s1_food  <= 1'b0;
      s1_obs   <= 1'b0;
      s1_out   <= 1'b0;
      s1_blank <= 1'b1;
      s1_dead  <= 1'b0;
      rgb      <= 3'b000;
    end else begin
      for (int i = 0; i < MAX_LEN; i++)
        s1_seg[i] <= (LW'(i) < len) && span(pos_h, seg_x[i]) && span(pos_v, seg_y[i]);
      s1_food  <= span(pos_h, food_x) && span(pos_v, food_y);
      s1_obs   <= (level >= 2'd1 && rng(pos_h, 1, 4)   && rng(pos_v, 1, 2)) ||
                  (level >= 2'd2 && rng(pos_h, 6, 9)   && rng(pos_v, 4, 5)) ||
                  (level == 2'd3 && rng(pos_h, 11, 14) && rng(pos_v, 7, 8));
      s1_out   <= !(rng(pos_h, 0, GRID_W-1) && rng(pos_v, 0, GRID_H-1));
      s1_blank <= blank;
      s1_dead  <= (st == DEAD);

      if (s1_blank)                    rgb <= 3'b000;
      else if (s1_out)                 rgb <= 3'b001;
      else if (s1_seg[0])              rgb <= 3'b011;
      else if (|s1_seg[MAX_LEN-1:1])   rgb <= s1_dead ? 3'b110 : 3'b010;
      else if (s1_food)                rgb <= 3'b100;
      else if (s1_obs)                 rgb <= 3'b101;
      else                             rgb <= 3'b000;
    end
  end

  assign red   = rgb[2];
  assign green = rgb[1];
  assign blue  = rgb[0];

endmodule
`default_nettype wire
